// File: rtl/accel_spi_reader.sv
// accel_spi_reader
//
// SPI mode-0 master for an ADXL362-class accelerometer. After a power-up wait it
// writes the power-control register once (measurement mode), then loops reading the
// 8-bit signed X-axis register. Each sample is offered to the downstream consumer
// through a completed/rescan handshake.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   rescan     consumer acknowledge (1 = sample taken, 0 = ready for the next one)
//   completed  x_reg holds a fresh, unconsumed sample
//   x_reg      last X sample, two's complement
//   init_done  configuration write finished (sticky until reset)
//   sclk       SPI clock (idle low)
//   cs_n       SPI chip select, active low
//   mosi       SPI data to the sensor (0 while cs_n is high)
//   miso       SPI data from the sensor
//
// Every transaction is 24 bits, MSB first. cs_n falls with the first bit already on
// mosi, sclk toggles every CLK_DIV cycles (48 edges), mosi shifts on falling edges,
// miso is captured on rising edges, and cs_n rises CLK_DIV cycles after the last
// falling edge.

module accel_spi_reader #(
  parameter int unsigned CLK_DIV        = 25,
  parameter int unsigned STARTUP_CYCLES = 250000,
  parameter int unsigned CS_GAP         = 10,
  parameter logic [7:0]  X_ADDR         = 8'h08,
  parameter logic [7:0]  PWR_ADDR       = 8'h2D,
  parameter logic [7:0]  PWR_VAL        = 8'h02
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rescan,
  output logic       completed,
  output logic [7:0] x_reg,
  output logic       init_done,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CntMax = (STARTUP_CYCLES > CS_GAP) ? STARTUP_CYCLES : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned DivW   = $clog2(CLK_DIV);

  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] StartLast = CntW'(STARTUP_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP - 1);
  // 48 sclk edges per frame; the 49th tick closes the frame.
  localparam logic [5:0]      LastEdge  = 6'd48;

  localparam logic [23:0] WrWord = {8'h0A, PWR_ADDR, PWR_VAL};
  localparam logic [23:0] RdWord = {8'h0B, X_ADDR, 8'h00};

  typedef enum logic [2:0] {
    StStartup,
    StInitXfer,
    StGap,
    StReadXfer,
    StHold,
    StPublish,
    StWaitAck
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      edge_q, edge_d;
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic [23:0]     tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [7:0]      x_reg_q, x_reg_d;
  logic            completed_q, completed_d;
  logic            init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    edge_d      = edge_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    shadow_d    = shadow_q;
    x_reg_d     = x_reg_q;
    completed_d = completed_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StStartup: begin
        if (cnt_q == StartLast) begin
          state_d = StInitXfer;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          tx_d    = WrWord;
          div_d   = '0;
          edge_d  = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StInitXfer, StReadXfer: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (edge_q == LastEdge) begin
            cs_n_d = 1'b1;
            cnt_d  = '0;
            if (state_q == StInitXfer) begin
              init_done_d = 1'b1;
              state_d     = StGap;
            end else begin
              // Last 8 captured bits are the data byte.
              shadow_d = rx_q;
              state_d  = StHold;
            end
          end else begin
            edge_d = edge_q + 6'd1;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              rx_d = {rx_q[6:0], miso};
            end else begin
              tx_d = {tx_q[22:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StReadXfer;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          tx_d    = RdWord;
          div_d   = '0;
          edge_d  = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // An acknowledge still high from the previous sample must not consume this one.
      StHold: begin
        if (!rescan) begin
          state_d = StPublish;
        end
      end

      StPublish: begin
        x_reg_d     = shadow_q;
        completed_d = 1'b1;
        state_d     = StWaitAck;
      end

      StWaitAck: begin
        if (rescan) begin
          completed_d = 1'b0;
          cnt_d       = '0;
          state_d     = StGap;
        end
      end

      default: begin
        state_d = StStartup;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StStartup;
      cnt_q       <= '0;
      div_q       <= '0;
      edge_q      <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      tx_q        <= '0;
      rx_q        <= '0;
      shadow_q    <= '0;
      x_reg_q     <= '0;
      completed_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      edge_q      <= edge_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      shadow_q    <= shadow_d;
      x_reg_q     <= x_reg_d;
      completed_q <= completed_d;
      init_done_q <= init_done_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = ~cs_n_q & tx_q[23];
  assign completed = completed_q;
  assign x_reg     = x_reg_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: an SPI slave model captures every frame and serves a
// chosen data byte; a publish model checks each completed sample against the byte
// returned by the most recent finished read.

module tb_accel_spi_reader;

  localparam int unsigned ClkDiv        = 2;
  localparam int unsigned StartupCycles = 20;
  localparam int unsigned CsGap         = 10;
  localparam int unsigned XferLow       = 49 * ClkDiv;

  logic       clk;
  logic       reset_n;
  logic       rescan;
  logic       completed;
  logic [7:0] x_reg;
  logic       init_done;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  accel_spi_reader #(
    .CLK_DIV       (ClkDiv),
    .STARTUP_CYCLES(StartupCycles),
    .CS_GAP        (CsGap),
    .X_ADDR        (8'h08),
    .PWR_ADDR      (8'h2D),
    .PWR_VAL       (8'h02)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rescan   (rescan),
    .completed(completed),
    .x_reg    (x_reg),
    .init_done(init_done),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  typedef struct {
    logic [23:0] word;
    int          pulses;
    int          low;
  } xfer_t;

  typedef struct {
    logic [7:0] x;
    logic [7:0] expect_x;
    bit         expect_valid;
  } pub_t;

  typedef struct {
    logic [7:0] miso_byte;
    int         ack_delay;
    logic [7:0] exp_x;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  xfer_t xfers[$];
  pub_t  pubs[$];
  int    xi = 0;
  int    pi = 0;

  logic [7:0] slave_byte;

  // Slave / monitor state
  logic        prev_cs        = 1'b1;
  logic        prev_sclk      = 1'b0;
  logic        prev_completed = 1'b0;
  logic        prev_rst       = 1'b0;
  logic [7:0]  prev_x         = 8'h00;
  logic [23:0] cur_word       = '0;
  logic [23:0] frame          = '0;
  int          cur_pulses     = 0;
  int          cur_low        = 0;
  int          bitidx         = 0;
  int          cs_falls       = 0;
  int          idle_viol      = 0;
  int          xreg_viol      = 0;
  logic [7:0]  last_read      = 8'h00;
  bit          last_read_ok   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin : mon
    logic [31:0] g;
    if (prev_cs && !cs_n) begin
      g          = $urandom();
      frame      = {g[15:0], slave_byte};
      cur_word   = '0;
      cur_pulses = 0;
      cur_low    = 0;
      bitidx     = 0;
      cs_falls++;
    end
    if (!cs_n) begin
      cur_low++;
      if (!prev_sclk && sclk) begin
        cur_word = {cur_word[22:0], mosi};
        cur_pulses++;
      end
      if (prev_sclk && !sclk) bitidx++;
    end else begin
      if (mosi || sclk) idle_viol++;
      if (!prev_cs) begin
        xfers.push_back('{word: cur_word, pulses: cur_pulses, low: cur_low});
        if (reset_n && cur_word == 24'h0B0800 && cur_pulses == 24) begin
          last_read    = frame[7:0];
          last_read_ok = 1'b1;
        end
      end
    end
    miso = (!cs_n && bitidx < 24) ? frame[23 - bitidx] : 1'b0;

    if (!reset_n) begin
      last_read_ok = 1'b0;
    end else if (prev_rst) begin
      if (completed && !prev_completed) begin
        pubs.push_back('{x: x_reg, expect_x: last_read, expect_valid: last_read_ok});
        last_read_ok = 1'b0;
      end else if (x_reg != prev_x) begin
        xreg_viol++;
      end
    end

    prev_cs        = cs_n;
    prev_sclk      = sclk;
    prev_completed = completed;
    prev_rst       = reset_n;
    prev_x         = x_reg;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic get_rec(input int budget, output xfer_t r);
    int n = 0;
    while (xfers.size() <= xi && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_seen", 32'(xfers.size() > xi), 32'd1);
    if (xfers.size() > xi) begin
      r = xfers[xi];
      xi++;
    end else begin
      r = '{word: '0, pulses: 0, low: 0};
    end
  endtask

  task automatic wait_completed(input int budget);
    int n = 0;
    while (!completed && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("completed_seen", 32'(completed), 32'd1);
  endtask

  task automatic chk_pub();
    int   n = 0;
    pub_t p;
    while (pubs.size() <= pi && n < 3) begin
      @(negedge clk);
      n++;
    end
    chk("pub_seen", 32'(pubs.size() > pi), 32'd1);
    if (pubs.size() > pi) begin
      p = pubs[pi];
      pi++;
      chk("model_pending", 32'(p.expect_valid), 32'd1);
      chk("model_x", 32'(p.x), 32'(p.expect_x));
    end
  endtask

  task automatic chk_read(input xfer_t r, input string name);
    chk(name, 32'(r.word), 32'h0B0800);
    chk("read_pulses", 32'(r.pulses), 32'd24);
    chk("read_cs_low", 32'(r.low), 32'(XferLow));
  endtask

  initial begin
    vec_t       vecs[6];
    xfer_t      r;
    int         n;
    int         bad;
    int         falls0;
    logic [7:0] x0;
    logic [7:0] b;

    vecs[0] = '{miso_byte: 8'hB0, ack_delay: 0,  exp_x: 8'hB0};
    vecs[1] = '{miso_byte: 8'h51, ack_delay: 3,  exp_x: 8'h51};
    vecs[2] = '{miso_byte: 8'h7F, ack_delay: 7,  exp_x: 8'h7F};
    vecs[3] = '{miso_byte: 8'h80, ack_delay: 1,  exp_x: 8'h80};
    vecs[4] = '{miso_byte: 8'h00, ack_delay: 12, exp_x: 8'h00};
    vecs[5] = '{miso_byte: 8'hFF, ack_delay: 0,  exp_x: 8'hFF};

    reset_n    = 1'b0;
    rescan     = 1'b0;
    slave_byte = vecs[0].miso_byte;
    repeat (5) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_completed", 32'(completed), 32'd0);
    chk("rst_x_reg", 32'(x_reg), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    reset_n = 1'b1;
    n = 0;
    while (cs_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("startup_delay", 32'(n), 32'(StartupCycles));

    get_rec(300, r);
    chk("init_word", 32'(r.word), 32'h0A2D02);
    chk("init_pulses", 32'(r.pulses), 32'd24);
    chk("init_cs_low", 32'(r.low), 32'(XferLow));
    chk("init_done_set", 32'(init_done), 32'd1);

    for (int i = 0; i < 6; i++) begin
      get_rec(300, r);
      chk_read(r, "read_word");
      wait_completed(20);
      chk("table_x", 32'(x_reg), 32'(vecs[i].exp_x));
      chk_pub();
      slave_byte = (i < 5) ? vecs[i + 1].miso_byte : 8'h3C;
      repeat (vecs[i].ack_delay) @(negedge clk);
      chk("hold_before_ack", 32'(completed), 32'd1);
      rescan = 1'b1;
      @(negedge clk);
      chk("ack_drop", 32'(completed), 32'd0);
      rescan = 1'b0;
    end

    // Consumer stalls: sample must stay put and no new read may start.
    get_rec(300, r);
    chk_read(r, "read_word");
    wait_completed(20);
    chk("hold_x", 32'(x_reg), 32'h3C);
    chk_pub();
    x0     = x_reg;
    falls0 = cs_falls;
    bad    = 0;
    repeat (500) begin
      @(negedge clk);
      if (!completed || x_reg !== x0) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    chk("hold_no_cs", 32'(cs_falls), 32'(falls0));

    // Ack and keep rescan high through the whole next read.
    slave_byte = 8'hAF;
    rescan     = 1'b1;
    @(negedge clk);
    n = 1;
    chk("ack_drop_hold", 32'(completed), 32'd0);
    while (cs_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gap_len", 32'(n), 32'(CsGap + 1));
    get_rec(300, r);
    chk_read(r, "stale_read_word");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (completed || x_reg !== x0) bad++;
    end
    chk("stale_ignored", 32'(bad), 32'd0);
    rescan = 1'b0;
    @(negedge clk);
    chk("stale_wait", 32'(completed), 32'd0);
    @(negedge clk);
    chk("stale_pub", 32'(completed), 32'd1);
    chk("stale_x", 32'(x_reg), 32'hAF);
    chk_pub();

    // Reset in the middle of a read.
    slave_byte = 8'h12;
    rescan     = 1'b1;
    @(negedge clk);
    rescan = 1'b0;
    falls0 = cs_falls;
    n = 0;
    while (cs_falls == falls0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    while (cur_pulses < 10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pulse10", 32'(!cs_n && cur_pulses >= 10), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs_n), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_mosi", 32'(mosi), 32'd0);
    chk("midrst_completed", 32'(completed), 32'd0);
    repeat (5) @(negedge clk);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    xi      = xfers.size();
    reset_n = 1'b1;
    get_rec(400, r);
    chk("reinit_word", 32'(r.word), 32'h0A2D02);
    get_rec(300, r);
    chk_read(r, "reread_word");
    wait_completed(20);
    chk("reread_x", 32'(x_reg), 32'h12);
    chk_pub();

    // Randomised bytes and consumer timing.
    for (int k = 0; k < 20; k++) begin
      b          = 8'($urandom());
      slave_byte = b;
      if ($urandom_range(0, 3) == 0) begin
        xi     = xfers.size();
        rescan = 1'b1;
        get_rec(300, r);
        chk_read(r, "rand_read_word");
        repeat ($urandom_range(0, 5)) @(negedge clk);
        chk("rand_stale", 32'(completed), 32'd0);
        rescan = 1'b0;
        wait_completed(5);
      end else begin
        rescan = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rescan = 1'b0;
        wait_completed(200);
      end
      chk("rand_x", 32'(x_reg), 32'(b));
      chk_pub();
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    chk("idle_pins", 32'(idle_viol), 32'd0);
    chk("x_reg_only_on_publish", 32'(xreg_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
